// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_MAX_CHANNELS = 256;

  // Index width for n channels, never narrower than one bit.
  function automatic int unsigned selW(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
module demux_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             outReady,
  output logic             outValid,
  output logic [WIDTH-1:0] dout,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain in the same cycle; data is never zeroed on drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && outReady) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign outValid = valid_q;
  assign dout     = data_q;
  assign free     = !valid_q || outReady;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with per-channel back-pressure.
// Optional broadcast mode enabled by defining DEMUX_STREAM_BROADCAST_EN.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = selW(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [WIDTH-1:0]          dataIn,
  input  logic [SEL_W-1:0]          selectLine,
`ifdef DEMUX_STREAM_BROADCAST_EN
  input  logic                      bcast,
`endif
  output logic [CHANNELS-1:0]       outValid,
  input  logic [CHANNELS-1:0]       outReady,
  output logic [CHANNELS*WIDTH-1:0] dataOut,
  output logic                      badSelect
);

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic                sel_in_range;
  logic                sel_free;
  logic                in_ready_c;
  logic                accept;
  logic                is_bcast;
  logic                bad_select_q, bad_select_d;

`ifdef DEMUX_STREAM_BROADCAST_EN
  assign is_bcast = bcast;
`else
  assign is_bcast = 1'b0;
`endif

  // Select decode and ready mux; independent of inValid to avoid a loop to the producer.
  always_comb begin
    sel_in_range = 32'(selectLine) < CHANNELS;
    sel_free     = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (selectLine == SEL_W'(k)) sel_free = free[k];
    end
    if (is_bcast) begin
      in_ready_c = &free;
    end else if (sel_in_range) begin
      in_ready_c = sel_free;
    end else begin
      in_ready_c = 1'b1;
    end
  end

  assign inReady = in_ready_c;
  assign accept  = inValid && in_ready_c;

  // Per-channel load strobes; out-of-range words load nothing.
  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      load[k] = accept && (is_bcast || (sel_in_range && (selectLine == SEL_W'(k))));
    end
    bad_select_d = accept && !is_bcast && !sel_in_range;
  end

  // One-cycle pulse flagging a dropped out-of-range word.
  always_ff @(posedge clk) begin
    if (!rstN) bad_select_q <= 1'b0;
    else       bad_select_q <= bad_select_d;
  end

  assign badSelect = bad_select_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rstN     (rstN),
      .load     (load[k]),
      .din      (dataIn),
      .outReady (outReady[k]),
      .outValid (outValid[k]),
      .dout     (dataOut[k*WIDTH +: WIDTH]),
      .free     (free[k])
    );
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench: 8-channel instance for the main paths, 6-channel instance for bad selects.
module tb_demux_stream_1ton;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready;
  logic [7:0]  data_in;
  logic [2:0]  sel;
  logic [7:0]  out_valid, out_ready;
  logic [63:0] data_out;
  logic        bad_sel;

  logic        in_valid6, in_ready6;
  logic [7:0]  data_in6;
  logic [2:0]  sel6;
  logic [5:0]  out_valid6, out_ready6;
  logic [47:0] data_out6;
  logic        bad6;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef DEMUX_STREAM_BROADCAST_EN
  logic bcast, bcast6;
`endif

  always #5 clk = ~clk;

  demux_stream_1ton #(.WIDTH(8), .CHANNELS(8)) dut8 (
    .clk(clk), .rstN(rst_n), .inValid(in_valid), .inReady(in_ready),
    .dataIn(data_in), .selectLine(sel),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .bcast(bcast),
`endif
    .outValid(out_valid), .outReady(out_ready), .dataOut(data_out), .badSelect(bad_sel)
  );

  demux_stream_1ton #(.WIDTH(8), .CHANNELS(6)) dut6 (
    .clk(clk), .rstN(rst_n), .inValid(in_valid6), .inReady(in_ready6),
    .dataIn(data_in6), .selectLine(sel6),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .bcast(bcast6),
`endif
    .outValid(out_valid6), .outReady(out_ready6), .dataOut(data_out6), .badSelect(bad6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] s8(input int k);
    return data_out[k*8 +: 8];
  endfunction

  function automatic logic [7:0] s6(input int k);
    return data_out6[k*8 +: 8];
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;  data_in = 8'h77;  sel = 3'd0;  out_ready = 8'hFF;
    in_valid6 = 1'b1; data_in6 = 8'h66; sel6 = 3'd0; out_ready6 = 6'h3F;
`ifdef DEMUX_STREAM_BROADCAST_EN
    bcast = 1'b0; bcast6 = 1'b0;
`endif

    // Reset held two cycles with inValid high
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_data_out", data_out, 64'h0);
      chk("rst_bad", 64'(bad_sel), 64'h0);
      chk("rst_out_valid6", 64'(out_valid6), 64'h0);
    end

    // Unicast 0xA5 to channel 3
    rst_n = 1'b1; in_valid6 = 1'b0;
    data_in = 8'hA5; sel = 3'd3; in_valid = 1'b1;
    #1 chk("uni_in_ready", 64'(in_ready), 64'h1);
    step();
    chk("uni_out_valid", 64'(out_valid), 64'h08);
    chk("uni_slice3", 64'(s8(3)), 64'hA5);
    chk("uni_bad", 64'(bad_sel), 64'h0);
    in_valid = 1'b0;
    step();
    chk("uni_drained", 64'(out_valid), 64'h0);
    chk("uni_slice3_kept", 64'(s8(3)), 64'hA5);

    // Back-pressure on channel 2
    out_ready = 8'hFB; data_in = 8'h11; sel = 3'd2; in_valid = 1'b1;
    step();
    chk("bp_first_valid", 64'(out_valid), 64'h04);
    chk("bp_first_data", 64'(s8(2)), 64'h11);
    data_in = 8'h22;
    #1 chk("bp_stall_ready", 64'(in_ready), 64'h0);
    step();
    chk("bp_stall_valid", 64'(out_valid), 64'h04);
    chk("bp_stall_data", 64'(s8(2)), 64'h11);
    out_ready = 8'hFF;
    #1 chk("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_refill_valid", 64'(out_valid), 64'h04);
    chk("bp_refill_data", 64'(s8(2)), 64'h22);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 64'(out_valid), 64'h0);

    // Independence: channel 5 stalled while 1 and 6 flow
    out_ready = 8'hDF; data_in = 8'h55; sel = 3'd5; in_valid = 1'b1;
    step();
    chk("ind_ch5_loaded", 64'(out_valid), 64'h20);
    data_in = 8'h33; sel = 3'd1;
    #1 chk("ind_ready1", 64'(in_ready), 64'h1);
    step();
    chk("ind_valid_a", 64'(out_valid), 64'h22);
    chk("ind_slice1", 64'(s8(1)), 64'h33);
    data_in = 8'h44; sel = 3'd6;
    step();
    chk("ind_valid_b", 64'(out_valid), 64'h60);
    chk("ind_slice6", 64'(s8(6)), 64'h44);
    chk("ind_slice5", 64'(s8(5)), 64'h55);
    chk("ind_slice1_kept", 64'(s8(1)), 64'h33);
    data_in = 8'h99; sel = 3'd5;
    #1 chk("ind_ready5_blocked", 64'(in_ready), 64'h0);
    in_valid = 1'b0;

    // Reset with a word still held
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_data", data_out, 64'h0);
    rst_n = 1'b1; out_ready = 8'hFF;

    // Bad select on the 6-channel instance
    out_ready6 = 6'h00; data_in6 = 8'h12; sel6 = 3'd0; in_valid6 = 1'b1;
    step();
    chk("bs_ch0_loaded", 64'(out_valid6), 64'h01);
    sel6 = 3'd7; data_in6 = 8'hFF;
    #1 chk("bs7_ready", 64'(in_ready6), 64'h1);
    step();
    chk("bs7_pulse", 64'(bad6), 64'h1);
    chk("bs7_valid", 64'(out_valid6), 64'h01);
    chk("bs7_data", 64'(data_out6), 64'h12);
    in_valid6 = 1'b0;
    step();
    chk("bs7_pulse_end", 64'(bad6), 64'h0);
    sel6 = 3'd6; data_in6 = 8'h3C; in_valid6 = 1'b1;
    #1 chk("bs6_ready", 64'(in_ready6), 64'h1);
    step();
    chk("bs6_pulse", 64'(bad6), 64'h1);
    chk("bs6_valid", 64'(out_valid6), 64'h01);
    sel6 = 3'd5; data_in6 = 8'h9C;
    step();
    chk("bs5_no_pulse", 64'(bad6), 64'h0);
    chk("bs5_valid", 64'(out_valid6), 64'h21);
    chk("bs5_slice5", 64'(s6(5)), 64'h9C);
    in_valid6 = 1'b0;
    chk("bs_dut8_quiet", 64'(bad_sel), 64'h0);

`ifdef DEMUX_STREAM_BROADCAST_EN
    // Broadcast stalls on a full, unready slot then loads every channel
    out_ready = 8'hFE; data_in = 8'h0F; sel = 3'd0; in_valid = 1'b1;
    step();
    chk("bc_ch0_loaded", 64'(out_valid), 64'h01);
    bcast = 1'b1; data_in = 8'h5A; sel = 3'd7;
    #1 chk("bc_stall_ready", 64'(in_ready), 64'h0);
    step();
    chk("bc_stall_valid", 64'(out_valid), 64'h01);
    chk("bc_stall_data", 64'(s8(0)), 64'h0F);
    out_ready = 8'hFF;
    #1 chk("bc_release_ready", 64'(in_ready), 64'h1);
    step();
    chk("bc_all_valid", 64'(out_valid), 64'hFF);
    chk("bc_all_data", data_out, 64'h5A5A5A5A5A5A5A5A);
    chk("bc_no_bad", 64'(bad_sel), 64'h0);
    in_valid = 1'b0; bcast = 1'b0;
    step();
    chk("bc_drained", 64'(out_valid), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
